// File: rtl/agc_timing_pkg.sv
// ----------------------------------------------------------------------------
// agc_timing_pkg : shared constants, state type and successor rule for the
//                  timing-pulse cascade.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package agc_timing_pkg;

  localparam int NUM_TP  = 10;
  localparam int PHASE_W = 4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  // Phase that must follow k in a clean cascade; 10 wraps back to 1.
  function automatic logic [PHASE_W-1:0] tp_succ(input logic [PHASE_W-1:0] k);
    return (k == PHASE_W'(NUM_TP)) ? PHASE_W'(1) : k + PHASE_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tp_onehot_encode.sv
// ----------------------------------------------------------------------------
// tp_onehot_encode : 10-bit one-hot to 1..10 index; zero/multi-hot give 0.
//                    Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tp_onehot_encode
  import agc_timing_pkg::*;
(
  input  logic [NUM_TP-1:0]  tp_vec,
  output logic [PHASE_W-1:0] index,
  output logic               valid
);

  // Exact-match compare so that unknown bits can never produce a phase.
  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_TP; i++) begin
      if (tp_vec == (NUM_TP'(1) << i)) begin
        index = PHASE_W'(i + 1);
      end
    end
  end

  assign valid = (index != '0);

endmodule

`default_nettype wire

// File: rtl/timepulse_decoder.sv
// ----------------------------------------------------------------------------
// timepulse_decoder : phase decode, lock tracking, cycle and violation
//                     counting for the tp1..tp10 cascade.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module timepulse_decoder
  import agc_timing_pkg::*;
#(
  parameter int MCT_WIDTH = 16,
  parameter int ERR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tp1,
  input  logic                 tp2,
  input  logic                 tp3,
  input  logic                 tp4,
  input  logic                 tp5,
  input  logic                 tp6,
  input  logic                 tp7,
  input  logic                 tp8,
  input  logic                 tp9,
  input  logic                 tp10,
  output logic [PHASE_W-1:0]   phase,
  output logic                 locked,
  output logic                 cycle_start,
  output logic [MCT_WIDTH-1:0] mct_count,
  output logic                 sync_err,
  output logic [ERR_WIDTH-1:0] err_count
);

  logic [NUM_TP-1:0]  tp_vec;
  logic [PHASE_W-1:0] enc_idx;
  logic               enc_valid;

  sync_state_t        state;
  sync_state_t        next_state;
  logic [PHASE_W-1:0] last;
  logic [PHASE_W-1:0] next_last;

  logic               step_ok;
  logic               is_tp1;
  logic               cycle_evt;
  logic               err_evt;

  assign tp_vec = {tp10, tp9, tp8, tp7, tp6, tp5, tp4, tp3, tp2, tp1};

  tp_onehot_encode u_encode (
    .tp_vec (tp_vec),
    .index  (enc_idx),
    .valid  (enc_valid)
  );

  assign step_ok = enc_valid && (enc_idx == tp_succ(last));
  assign is_tp1  = (enc_idx == PHASE_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
      last  <= '0;
    end else begin
      state <= next_state;
      last  <= next_last;
    end
  end

  always_comb begin
    next_state = state;
    next_last  = last;
    case (state)
      SEARCH: begin
        if (is_tp1) begin
          next_state = TRACK;
          next_last  = PHASE_W'(1);
        end
      end
      TRACK, LOCKED: begin
        if (step_ok) begin
          next_last = enc_idx;
          if (is_tp1) begin
            next_state = LOCKED;
          end
        end else if (is_tp1) begin
          // A stray tp1 is still a plausible start of a new cascade.
          next_state = TRACK;
          next_last  = PHASE_W'(1);
        end else begin
          next_state = SEARCH;
          next_last  = '0;
        end
      end
      default: begin
        next_state = SEARCH;
        next_last  = '0;
      end
    endcase
  end

  always_comb begin
    cycle_evt = 1'b0;
    err_evt   = 1'b0;
    if (state != SEARCH) begin
      cycle_evt = step_ok && is_tp1;
    end
    if (state == LOCKED) begin
      err_evt = !step_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase       <= '0;
      cycle_start <= 1'b0;
      sync_err    <= 1'b0;
      mct_count   <= '0;
      err_count   <= '0;
    end else begin
      phase       <= enc_idx;
      cycle_start <= cycle_evt;
      sync_err    <= err_evt;
      if (cycle_evt) begin
        mct_count <= mct_count + MCT_WIDTH'(1);
      end
      if (err_evt && (err_count != '1)) begin
        err_count <= err_count + ERR_WIDTH'(1);
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

`default_nettype wire

// File: tb/tb_timepulse_decoder.sv
// ----------------------------------------------------------------------------
// tb_timepulse_decoder : directed self-checking bench for timepulse_decoder.
//                        Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_timepulse_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  tpv;
  logic [3:0]  phase;
  logic        locked;
  logic        cycle_start;
  logic [15:0] mct_count;
  logic        sync_err;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fails  = 0;

  timepulse_decoder #(.MCT_WIDTH(16), .ERR_WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .tp1         (tpv[0]),
    .tp2         (tpv[1]),
    .tp3         (tpv[2]),
    .tp4         (tpv[3]),
    .tp5         (tpv[4]),
    .tp6         (tpv[5]),
    .tp7         (tpv[6]),
    .tp8         (tpv[7]),
    .tp9         (tpv[8]),
    .tp10        (tpv[9]),
    .phase       (phase),
    .locked      (locked),
    .cycle_start (cycle_start),
    .mct_count   (mct_count),
    .sync_err    (sync_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] oh(input int k);
    return 10'd1 << (k - 1);
  endfunction

  // Apply one sample just after an edge, then look at the result 1 ns after
  // the edge that captured it.
  task automatic drive(input logic [9:0] v);
    tpv = v;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int a, input int b);
    for (int k = a; k <= b; k++) drive(oh(k));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_phase"},  32'(phase),       32'd0);
    check({tag, "_locked"}, 32'(locked),      32'd0);
    check({tag, "_cycle"},  32'(cycle_start), 32'd0);
    check({tag, "_serr"},   32'(sync_err),    32'd0);
    check({tag, "_mct"},    32'(mct_count),   32'd0);
    check({tag, "_err"},    32'(err_count),   32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_err;
    int first_lock;
    int serr_seen;

    reset = 1'b1;
    tpv   = '0;
    #3;
    check_all_zero("reset");
    #9;
    reset = 1'b0;

    // Clean cascade from reset
    drive(oh(1));
    check("cas_phase1", 32'(phase), 32'd1);
    check("cas_locked1", 32'(locked), 32'd0);
    run(2, 9);
    drive(oh(10));
    check("cas_phase10", 32'(phase), 32'd10);
    check("cas_locked10", 32'(locked), 32'd0);
    check("cas_mct10", 32'(mct_count), 32'd0);
    drive(oh(1));
    check("cas_phase11", 32'(phase), 32'd1);
    check("cas_locked11", 32'(locked), 32'd1);
    check("cas_cycle11", 32'(cycle_start), 32'd1);
    check("cas_mct11", 32'(mct_count), 32'd1);
    drive(oh(2));
    check("cas_cycle12", 32'(cycle_start), 32'd0);
    run(3, 10); drive(oh(1));
    run(2, 10); drive(oh(1));
    run(2, 10); drive(oh(1));
    check("cas_mct4", 32'(mct_count), 32'd4);
    check("cas_err0", 32'(err_count), 32'd0);
    check("cas_locked", 32'(locked), 32'd1);

    // Held tp5
    run(2, 4);
    drive(oh(5));
    check("hold_first_serr", 32'(sync_err), 32'd0);
    drive(oh(5));
    check("hold_phase", 32'(phase), 32'd5);
    check("hold_serr", 32'(sync_err), 32'd1);
    check("hold_err", 32'(err_count), 32'd1);
    check("hold_locked", 32'(locked), 32'd0);
    drive(oh(6));
    check("hold_serr_clear", 32'(sync_err), 32'd0);
    run(7, 10);
    drive(oh(1));
    check("hold_track", 32'(locked), 32'd0);
    run(2, 10);
    check("hold_prelock", 32'(locked), 32'd0);
    drive(oh(1));
    check("hold_relock", 32'(locked), 32'd1);
    check("hold_mct", 32'(mct_count), 32'd5);

    // All-zero and multi-hot samples while locked
    drive(oh(2));
    drive(10'd0);
    check("zero_phase", 32'(phase), 32'd0);
    check("zero_serr", 32'(sync_err), 32'd1);
    check("zero_err", 32'(err_count), 32'd2);
    check("zero_locked", 32'(locked), 32'd0);
    drive(oh(1)); run(2, 10); drive(oh(1));
    check("zero_relock", 32'(locked), 32'd1);
    check("zero_mct", 32'(mct_count), 32'd6);
    run(2, 3);
    drive(10'b00_0000_1100);
    check("multi_phase", 32'(phase), 32'd0);
    check("multi_serr", 32'(sync_err), 32'd1);
    check("multi_err", 32'(err_count), 32'd3);

    // Premature tp1 at last=6
    drive(oh(1)); run(2, 10); drive(oh(1));
    check("skip_pre_mct", 32'(mct_count), 32'd7);
    check("skip_pre_locked", 32'(locked), 32'd1);
    run(2, 6);
    drive(oh(1));
    check("skip_serr", 32'(sync_err), 32'd1);
    check("skip_locked", 32'(locked), 32'd0);
    check("skip_err", 32'(err_count), 32'd4);
    check("skip_phase", 32'(phase), 32'd1);
    run(2, 10);
    check("skip_track_locked", 32'(locked), 32'd0);
    check("skip_track_serr", 32'(sync_err), 32'd0);
    drive(oh(1));
    check("skip_relock", 32'(locked), 32'd1);
    check("skip_cycle", 32'(cycle_start), 32'd1);
    check("skip_mct", 32'(mct_count), 32'd8);

    // 300 violations, each followed by a relock
    for (int i = 0; i < 300; i++) begin
      drive(oh(1));
      exp_err = (5 + i > 255) ? 255 : 5 + i;
      check("sat_serr", 32'(sync_err), 32'd1);
      check("sat_err", 32'(err_count), 32'(exp_err));
      run(2, 10);
      drive(oh(1));
    end
    check("sat_final_err", 32'(err_count), 32'd255);
    check("sat_final_mct", 32'(mct_count), 32'd308);
    check("sat_final_locked", 32'(locked), 32'd1);

    // Asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("areset");
    #2;
    reset = 1'b0;

    // Power-up garbage, then a free-running generator
    for (int i = 0; i < 3; i++) drive(10'h3FF);
    check("garbage_phase", 32'(phase), 32'd0);
    check("garbage_locked", 32'(locked), 32'd0);
    check("garbage_err", 32'(err_count), 32'd0);
    first_lock = 0;
    serr_seen  = 0;
    for (int n = 1; n <= 50; n++) begin
      drive(oh(((n - 1) % 10) + 1));
      if (locked && first_lock == 0) first_lock = n;
      if (sync_err) serr_seen++;
    end
    check("gen_first_lock", 32'(first_lock), 32'd11);
    check("gen_serr", 32'(serr_seen), 32'd0);
    check("gen_mct", 32'(mct_count), 32'd4);
    check("gen_err", 32'(err_count), 32'd0);
    check("gen_locked", 32'(locked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/timepulse_decoder.md
# timepulse_decoder

Receive-side companion to `sequence_generator`. It samples the ten one-hot timing pulses `tp1`..`tp10` every clock and encodes the active pulse to a phase number. It also acquires and tracks lock on the 1→10 cascade, counts completed memory cycles, and flags sequence violations. Downstream control logic in the simulator gates its per-phase actions on `phase` and `locked` rather than decoding the raw pulses itself.

## Interface
Parameters:
- `MCT_WIDTH`, default 16: width of the memory-cycle counter.
- `ERR_WIDTH`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1: sole clock; all sampling on posedge.
- `reset`  in  1: asynchronous, active-high reset.
- `tp1`..`tp10`  in  1 each: timing pulses from `sequence_generator`.
- `phase`  out  4: index of the sampled pulse, 1..10; 0 if the sample is not exactly one-hot.
- `locked`  out  1: high while the state is LOCKED.
- `cycle_start`  out  1: one-cycle pulse on each valid tp10→tp1 step while in TRACK or LOCKED.
- `mct_count`  out  MCT_WIDTH: count of completed memory cycles; wraps modulo 2^MCT_WIDTH.
- `sync_err`  out  1: one-cycle pulse on a sequence violation while in LOCKED.
- `err_count`  out  ERR_WIDTH: count of violations; saturates at all-ones.

## Operation
- Each posedge samples vector v = {tp10..tp1}. enc(v) = k if only tp_k is high, else 0.
- Successor rule: succ(k) = k+1 for k=1..9, and succ(10) = 1.
- The FSM holds `last`, the previous valid phase (4 bits).

States:
- SEARCH
  - enc(v)=1 → TRACK, `last`=1.
  - Anything else: stay in SEARCH; no error is raised.
- TRACK
  - enc(v)=succ(`last`) → update `last`.
  - If that step is 10→1: go to LOCKED, pulse `cycle_start`, increment `mct_count`.
  - Any other sample → SEARCH, no error. Exception: if enc(v)=1, restart TRACK with `last`=1.
- LOCKED
  - enc(v)=succ(`last`) → update `last`.
  - On a 10→1 step: pulse `cycle_start`, increment `mct_count`.
  - Any other sample (repeat, skip, zero, multi-hot) → pulse `sync_err`, increment `err_count` (saturating), go to SEARCH.
  - Same exception: if the offending enc(v)=1, go to TRACK with `last`=1, still raising the error.
- A held pulse is a violation, because the generator advances every clock.
- `mct_count` is not cleared by loss of lock; only `reset` clears it.
- Saturation: at the all-ones value `err_count` holds, but `sync_err` still pulses on each violation.

## Timing
- All outputs are registered. Each output reflects the sample taken at the same edge, so `phase` lags the tp inputs by one clock.
- A clean cascade starting at tp1 sets `locked` at the edge that samples the second tp1, i.e. the 11th valid sample.
- `locked` falls at the same edge that raises `sync_err`.
- `reset` asserted, at any time and without a clock edge: `phase`=0, `locked`=0, `cycle_start`=0, `sync_err`=0, `mct_count`=0, `err_count`=0, state=SEARCH, `last`=0.
- After `reset` deasserts, the first posedge samples normally.
- X or multi-hot inputs (e.g. generator power-up before its registers are written) encode to 0. These are silently ignored in SEARCH.

## Structure
- Package `agc_timing_pkg` holds:
  - `NUM_TP` = 10.
  - The state enum {SEARCH, TRACK, LOCKED}.
  - The function `tp_succ`.
- One sub-module is natural: `tp_onehot_encode`, a combinational 10-bit one-hot to 4-bit index converter with a valid flag (0 on zero or multi-hot input).
- The top level holds the FSM, the counters and the output registers.

## Test plan
- Clean cascade: drive tp1..tp10 one-hot, one per clock, from reset.
  - `phase` steps 1..10 with one cycle lag.
  - `locked`=1, `cycle_start` pulses and `mct_count`=1 at the 11th sample.
  - After 3 more cycles, `mct_count`=4 and `err_count`=0.
- Held pulse: while locked, hold tp5 for 2 clocks.
  - Second sample gives `phase`=5, `sync_err` pulse, `err_count`=1, `locked`=0.
  - Relock 10 samples after the next tp1.
- Zero and multi-hot: while locked, drive all-zero, then later tp3|tp4.
  - Each gives `phase`=0, one `sync_err`, and `err_count` +1.
- Skip to tp1: while locked at `last`=6, drive tp1.
  - `sync_err`=1, state TRACK, `locked`=0.
  - Continuing tp2..tp10, tp1 relocks with `mct_count` +1.
- Saturation: inject 300 violations → `err_count`=255 and holds; `sync_err` still pulses on each.
- Async reset and integration:
  - Assert `reset` between edges mid-cycle → all outputs 0 before the next edge.
  - Drive from `sequence_generator` free-running for 500 ns → `locked` within 12 clocks of first tp1, then no `sync_err`.
